// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, goal scoring via external BCD counters,
// win detection and restart. All FSM activity advances on en ticks only.
module pong_match_ctrl #(
   parameter int BCD_DIGITS  = 2,
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_DELAY = 60
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    en,
   input  logic                    start,
   input  logic                    goal_l,
   input  logic                    goal_r,
   input  logic [BCD_DIGITS*4-1:0] score_l,
   input  logic [BCD_DIGITS*4-1:0] score_r,
   output logic                    inc_l,
   output logic                    inc_r,
   output logic                    score_rst,
   output logic                    ball_release,
   output logic                    serve_dir,
   output logic                    game_over,
   output logic                    winner,
   output logic [2:0]              state
);

   localparam int DW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
   localparam logic [DW-1:0] DELAY_LOAD = DW'(SERVE_DELAY - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      SCORE = 3'd3,
      CHECK = 3'd4,
      OVER  = 3'd5
   } state_t;

   state_t          st_q, st_n;
   logic [DW-1:0]   delay_q, delay_n;
   logic            scorer_q, scorer_n;
   logic            start_f, goal_l_f, goal_r_f;
   logic            start_clr, goal_l_clr, goal_r_clr;
   logic            inc_l_n, inc_r_n, score_rst_n, ball_release_n;
   logic            serve_dir_n, game_over_n, winner_n;
   int              score_bin;

   function automatic int bcd_to_bin(input logic [BCD_DIGITS*4-1:0] d);
      int acc;
      acc = 0;
      for (int i = BCD_DIGITS - 1; i >= 0; i--)
         acc = acc * 10 + int'({28'd0, d[i*4 +: 4]});
      return acc;
   endfunction

   // The scorer's counter has already taken its increment by the CHECK tick.
   assign score_bin = bcd_to_bin(scorer_q ? score_r : score_l);
   assign state     = st_q;

   always_comb begin
      st_n           = st_q;
      delay_n        = delay_q;
      scorer_n       = scorer_q;
      inc_l_n        = inc_l;
      inc_r_n        = inc_r;
      score_rst_n    = score_rst;
      ball_release_n = ball_release;
      serve_dir_n    = serve_dir;
      game_over_n    = game_over;
      winner_n       = winner;
      start_clr      = 1'b0;
      goal_l_clr     = 1'b0;
      goal_r_clr     = 1'b0;
      if (en) begin
         inc_l_n        = 1'b0;
         inc_r_n        = 1'b0;
         score_rst_n    = 1'b0;
         ball_release_n = 1'b0;
         case (st_q)
            IDLE: begin
               if (start_f) begin
                  start_clr   = 1'b1;
                  score_rst_n = 1'b1;
                  serve_dir_n = 1'b0;
                  delay_n     = DELAY_LOAD;
                  st_n        = SERVE;
               end
            end
            SERVE: begin
               start_clr  = 1'b1;
               goal_l_clr = 1'b1;
               goal_r_clr = 1'b1;
               if (delay_q == '0) begin
                  ball_release_n = 1'b1;
                  st_n           = PLAY;
               end else begin
                  delay_n = delay_q - DW'(1);
               end
            end
            PLAY: begin
               start_clr = 1'b1;
               if (goal_l_f && goal_r_f) begin
                  goal_l_clr = 1'b1;
                  goal_r_clr = 1'b1;
                  delay_n    = DELAY_LOAD;
                  st_n       = SERVE;
               end else if (goal_l_f) begin
                  goal_l_clr = 1'b1;
                  inc_l_n    = 1'b1;
                  scorer_n   = 1'b0;
                  st_n       = SCORE;
               end else if (goal_r_f) begin
                  goal_r_clr = 1'b1;
                  inc_r_n    = 1'b1;
                  scorer_n   = 1'b1;
                  st_n       = SCORE;
               end
            end
            SCORE: begin
               start_clr = 1'b1;
               st_n      = CHECK;
            end
            CHECK: begin
               start_clr = 1'b1;
               if (score_bin >= WIN_SCORE) begin
                  game_over_n = 1'b1;
                  winner_n    = scorer_q;
                  st_n        = OVER;
               end else begin
                  serve_dir_n = ~scorer_q;
                  delay_n     = DELAY_LOAD;
                  st_n        = SERVE;
               end
            end
            OVER: begin
               goal_l_clr = 1'b1;
               goal_r_clr = 1'b1;
               if (start_f) begin
                  start_clr   = 1'b1;
                  game_over_n = 1'b0;
                  score_rst_n = 1'b1;
                  serve_dir_n = 1'b0;
                  delay_n     = DELAY_LOAD;
                  st_n        = SERVE;
               end
            end
            default: st_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         st_q         <= IDLE;
         delay_q      <= '0;
         scorer_q     <= 1'b0;
         start_f      <= 1'b0;
         goal_l_f     <= 1'b0;
         goal_r_f     <= 1'b0;
         inc_l        <= 1'b0;
         inc_r        <= 1'b0;
         score_rst    <= 1'b0;
         ball_release <= 1'b0;
         serve_dir    <= 1'b0;
         game_over    <= 1'b0;
         winner       <= 1'b0;
      end else begin
         st_q         <= st_n;
         delay_q      <= delay_n;
         scorer_q     <= scorer_n;
         // A new request arriving on the consuming edge is kept.
         start_f      <= (start_f  & ~start_clr)  | start;
         goal_l_f     <= (goal_l_f & ~goal_l_clr) | goal_l;
         goal_r_f     <= (goal_r_f & ~goal_r_clr) | goal_r;
         inc_l        <= inc_l_n;
         inc_r        <= inc_r_n;
         score_rst    <= score_rst_n;
         ball_release <= ball_release_n;
         serve_dir    <= serve_dir_n;
         game_over    <= game_over_n;
         winner       <= winner_n;
      end
   end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: behavioural BCD counters plus a points-level
// match model; random goal sequences, en gating and async reset.
module tb_pong_match_ctrl;
   localparam int BD  = 2;
   localparam int WIN = 11;
   localparam int SD  = 3;

   logic clk = 1'b0, arst = 1'b1, en = 1'b0;
   logic start = 1'b0, goal_l = 1'b0, goal_r = 1'b0;
   logic [BD*4-1:0] score_l, score_r;
   logic inc_l, inc_r, score_rst, ball_release, serve_dir, game_over, winner;
   logic [2:0] state;

   int n_vec = 0, n_err = 0;
   int ml = 0, mr = 0;
   int cl = 0, cr = 0;
   int en_period = 1, tick_cnt = 0, cycle_cnt = 0;

   pong_match_ctrl #(.BCD_DIGITS(BD), .WIN_SCORE(WIN), .SERVE_DELAY(SD)) dut (
      .clk(clk), .arst(arst), .en(en), .start(start), .goal_l(goal_l), .goal_r(goal_r),
      .score_l(score_l), .score_r(score_r), .inc_l(inc_l), .inc_r(inc_r),
      .score_rst(score_rst), .ball_release(ball_release), .serve_dir(serve_dir),
      .game_over(game_over), .winner(winner), .state(state));

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int v);
      return 8'((((v / 10) % 10) << 4) | (v % 10));
   endfunction

   // Tick/cycle counters and the en gating pattern.
   initial forever begin
      @(posedge clk);
      cycle_cnt++;
      if (en) tick_cnt++;
      #2;
      en = (en_period <= 1) || (cycle_cnt % en_period == 0);
   end

   // Score counters as seen by the display path: two-digit decimal.
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         cl <= 0; cr <= 0;
      end else if (en) begin
         if (score_rst) begin
            cl <= 0; cr <= 0;
         end else begin
            if (inc_l) cl <= (cl + 1) % 100;
            if (inc_r) cr <= (cr + 1) % 100;
         end
      end
   end
   assign score_l = bcd(cl);
   assign score_r = bcd(cr);

   task automatic next_tick();
      int t0;
      t0 = tick_cnt;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         if (tick_cnt != t0) break;
      end
   endtask

   task automatic pulse(input bit s, input bit gl, input bit gr);
      start = s; goal_l = gl; goal_r = gr;
      @(posedge clk); #1;
      start = 1'b0; goal_l = 1'b0; goal_r = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s);
      for (int i = 0; i < 100 && state !== s; i++) next_tick();
   endtask

   task automatic wait_release(output int ticks, output int cycles);
      int t0, c0;
      t0 = tick_cnt; c0 = cycle_cnt;
      for (int i = 0; i < 100 && ball_release !== 1'b1; i++) next_tick();
      ticks = tick_cnt - t0; cycles = cycle_cnt - c0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      pulse(1'b1, 1'b1, 1'b1);
      repeat (2) @(posedge clk); #1;
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
      n_vec++; if ({inc_l, inc_r, score_rst, ball_release, serve_dir, game_over, winner} !== 7'd0) begin
         n_err++; $display("FAIL reset_outs got %b want 0000000", {inc_l, inc_r, score_rst, ball_release, serve_dir, game_over, winner}); end
      arst = 1'b0;
      repeat (4) next_tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL idle_no_start got %0d want 0", state); end
   endtask

   task automatic test_start();
      int t, c;
      pulse(1'b1, 1'b0, 1'b0);
      wait_state(3'd1);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL start_serve got %0d want 1", state); end
      n_vec++; if ({score_rst, serve_dir, game_over} !== 3'b100) begin
         n_err++; $display("FAIL start_outs rst/dir/over got %b want 100", {score_rst, serve_dir, game_over}); end
      wait_release(t, c);
      n_vec++; if (t != SD || c != en_period * SD) begin
         n_err++; $display("FAIL start_release ticks=%0d cycles=%0d want %0d/%0d", t, c, SD, en_period * SD); end
      n_vec++; if (state !== 3'd2 || score_rst !== 1'b0) begin
         n_err++; $display("FAIL start_play state=%0d rst=%b want 2/0", state, score_rst); end
      n_vec++; if (score_l !== 8'h00 || score_r !== 8'h00) begin
         n_err++; $display("FAIL start_clear got %h/%h want 00/00", score_l, score_r); end
      next_tick();
      n_vec++; if (ball_release !== 1'b0 || state !== 3'd2) begin
         n_err++; $display("FAIL release_once rel=%b state=%0d want 0/2", ball_release, state); end
      ml = 0; mr = 0;
   endtask

   task automatic test_point(input bit right);
      int t, c, k;
      k = $urandom_range(0, 3);
      repeat (k) next_tick();
      pulse(1'b0, !right, right);
      wait_state(3'd3);
      n_vec++; if (state !== 3'd3 || {inc_l, inc_r} !== (right ? 2'b01 : 2'b10) || score_rst !== 1'b0) begin
         n_err++; $display("FAIL point_inc state=%0d inc=%b rst=%b want 3/%b/0", state, {inc_l, inc_r}, score_rst, right ? 2'b01 : 2'b10); end
      next_tick();
      if (right) mr++; else ml++;
      n_vec++; if (state !== 3'd4 || {inc_l, inc_r} !== 2'b00) begin
         n_err++; $display("FAIL point_check state=%0d inc=%b want 4/00", state, {inc_l, inc_r}); end
      n_vec++; if (score_l !== bcd(ml) || score_r !== bcd(mr)) begin
         n_err++; $display("FAIL point_score got %h/%h want %h/%h", score_l, score_r, bcd(ml), bcd(mr)); end
      next_tick();
      if ((right ? mr : ml) >= WIN) begin
         n_vec++; if (state !== 3'd5 || game_over !== 1'b1 || winner !== right) begin
            n_err++; $display("FAIL point_win state=%0d over=%b winner=%b want 5/1/%b", state, game_over, winner, right); end
      end else begin
         n_vec++; if (state !== 3'd1 || serve_dir !== !right || game_over !== 1'b0) begin
            n_err++; $display("FAIL point_serve state=%0d dir=%b over=%b want 1/%b/0", state, serve_dir, game_over, !right); end
         wait_release(t, c);
         n_vec++; if (t != SD || c != en_period * SD || state !== 3'd2) begin
            n_err++; $display("FAIL point_release ticks=%0d cycles=%0d state=%0d want %0d/%0d/2", t, c, state, SD, en_period * SD); end
      end
   endtask

   task automatic test_both_goals();
      int t, c;
      bit sd0, saw;
      sd0 = serve_dir; saw = 1'b0;
      pulse(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20 && state !== 3'd1; i++) begin
         next_tick();
         if (inc_l || inc_r) saw = 1'b1;
      end
      n_vec++; if (state !== 3'd1 || saw || serve_dir !== sd0) begin
         n_err++; $display("FAIL both_goals state=%0d inc_seen=%b dir=%b want 1/0/%b", state, saw, serve_dir, sd0); end
      wait_release(t, c);
      n_vec++; if (t != SD || score_l !== bcd(ml) || score_r !== bcd(mr)) begin
         n_err++; $display("FAIL both_release ticks=%0d scores=%h/%h want %0d %h/%h", t, score_l, score_r, SD, bcd(ml), bcd(mr)); end
   endtask

   task automatic test_start_ignored();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) next_tick();
      n_vec++; if (state !== 3'd2 || score_rst !== 1'b0) begin
         n_err++; $display("FAIL start_in_play state=%0d rst=%b want 2/0", state, score_rst); end
   endtask

   task automatic test_match();
      int r, guard;
      guard = 0;
      while (ml < WIN && mr < WIN && guard < 60) begin
         r = $urandom_range(0, 5);
         if (r == 0) test_both_goals();
         else test_point(r >= 4);
         guard++;
      end
      n_vec++; if (state !== 3'd5) begin n_err++; $display("FAIL match_end state=%0d want 5", state); end
   endtask

   task automatic test_over();
      bit saw;
      saw = 1'b0;
      pulse(1'b0, 1'b0, 1'b1);
      repeat (4) begin next_tick(); if (inc_l || inc_r) saw = 1'b1; end
      n_vec++; if (saw || state !== 3'd5 || game_over !== 1'b1 || winner !== (mr >= WIN)) begin
         n_err++; $display("FAIL over_hold inc_seen=%b state=%0d over=%b winner=%b want 0/5/1/%b", saw, state, game_over, winner, mr >= WIN); end
      n_vec++; if (score_l !== bcd(ml) || score_r !== bcd(mr)) begin
         n_err++; $display("FAIL over_scores got %h/%h want %h/%h", score_l, score_r, bcd(ml), bcd(mr)); end
   endtask

   task automatic test_arst_mid();
      pulse(1'b0, 1'b1, 1'b0);
      wait_state(3'd3);
      n_vec++; if (inc_l !== 1'b1) begin n_err++; $display("FAIL pre_arst inc_l got %b want 1", inc_l); end
      #1 arst = 1'b1;
      #1;
      n_vec++; if (state !== 3'd0 || {inc_l, inc_r, score_rst, ball_release, serve_dir, game_over, winner} !== 7'd0) begin
         n_err++; $display("FAIL arst_mid state=%0d outs=%b want 0/0000000", state, {inc_l, inc_r, score_rst, ball_release, serve_dir, game_over, winner}); end
      #2 arst = 1'b0;
      ml = 0; mr = 0;
   endtask

   initial begin
      test_reset();
      test_start();
      test_point(1'b0);
      test_both_goals();
      test_start_ignored();
      test_match();
      test_over();
      test_start();
      test_point(1'b1);
      test_arst_mid();
      en_period = 4;
      repeat (8) @(posedge clk); #1;
      test_start();
      test_point(1'b0);
      test_point(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
